// File: rtl/level_sequencer.sv
// Game-flow controller: sequences play, level-clear, time-bonus, death and game-over phases,
// and owns the level timer, lives counter and level number. All outputs are registered.
module level_sequencer #(
  parameter int FPS           = 60,
  parameter int TIME_INIT     = 300,
  parameter int LIVES_INIT    = 3,
  parameter int MAX_LEVEL     = 15,
  parameter int BANNER_FRAMES = 120,
  parameter int BONUS_PTS     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        start_i,
  input  logic        level_done_i,
  input  logic        hero_dead_i,
  output logic        play_enable_o,
  output logic        hero_rst_o,
  output logic        bonus_valid_o,
  output logic [11:0] bonus_pts_o,
  output logic [3:0]  level_o,
  output logic [2:0]  lives_o,
  output logic [9:0]  timer_sec_o,
  output logic [1:0]  banner_o
);

  localparam int BW = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;

  localparam logic [5:0]    FPS_LAST = 6'(FPS - 1);
  localparam logic [BW-1:0] BAN_LAST = BW'(BANNER_FRAMES - 1);
  localparam logic [BW-1:0] BAN_ONE  = BW'(1);
  localparam logic [9:0]    T_INIT   = 10'(TIME_INIT);
  localparam logic [2:0]    L_INIT   = 3'(LIVES_INIT);
  localparam logic [3:0]    LVL_MAX  = 4'(MAX_LEVEL);
  localparam logic [11:0]   PTS      = 12'(BONUS_PTS);

  localparam logic [1:0] B_NONE  = 2'd0;
  localparam logic [1:0] B_CLEAR = 2'd1;
  localparam logic [1:0] B_DEATH = 2'd2;
  localparam logic [1:0] B_OVER  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_CLEAR, S_BONUS, S_RELOAD, S_DEATH, S_OVER
  } state_t;

  state_t        state_q;
  logic [5:0]    sub_q;
  logic [BW-1:0] ban_cnt_q;
  logic [9:0]    timer_q;
  logic [2:0]    lives_q;
  logic [3:0]    level_q;
  logic          play_q;
  logic          hrst_q;
  logic          bv_q;
  logic [11:0]   pts_q;
  logic [1:0]    banner_q;

  logic sec_wrap;
  logic ban_done;

  assign sec_wrap = frame_tick_i && (sub_q == FPS_LAST);
  assign ban_done = frame_tick_i && (ban_cnt_q == BAN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sub_q     <= '0;
      ban_cnt_q <= '0;
      timer_q   <= T_INIT;
      lives_q   <= L_INIT;
      level_q   <= '0;
      play_q    <= 1'b0;
      hrst_q    <= 1'b0;
      bv_q      <= 1'b0;
      pts_q     <= '0;
      banner_q  <= B_NONE;
    end else begin
      hrst_q <= 1'b0;
      bv_q   <= 1'b0;
      pts_q  <= '0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_i) begin
            state_q  <= S_PLAY;
            play_q   <= 1'b1;
            hrst_q   <= 1'b1;
            lives_q  <= L_INIT;
            level_q  <= '0;
            timer_q  <= T_INIT;
            sub_q    <= '0;
            banner_q <= B_NONE;
          end
        end
        S_PLAY: begin
          if (frame_tick_i) sub_q <= sec_wrap ? 6'd0 : sub_q + 6'd1;
          if (sec_wrap && timer_q != 10'd0) timer_q <= timer_q - 10'd1;
          // level_done outranks hero_dead, which outranks the timer running out
          if (level_done_i) begin
            state_q   <= S_CLEAR;
            play_q    <= 1'b0;
            banner_q  <= B_CLEAR;
            ban_cnt_q <= '0;
          end else if (hero_dead_i || (sec_wrap && timer_q <= 10'd1)) begin
            state_q   <= S_DEATH;
            play_q    <= 1'b0;
            banner_q  <= B_DEATH;
            ban_cnt_q <= '0;
            lives_q   <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end
        end
        S_CLEAR: begin
          if (ban_done) begin
            state_q   <= S_BONUS;
            ban_cnt_q <= '0;
          end else if (frame_tick_i) begin
            ban_cnt_q <= ban_cnt_q + BAN_ONE;
          end
        end
        S_BONUS: begin
          if (frame_tick_i) begin
            if (timer_q != 10'd0) begin
              timer_q <= timer_q - 10'd1;
              bv_q    <= 1'b1;
              pts_q   <= PTS;
            end else begin
              // RELOAD's outputs appear on the edge that enters it
              state_q  <= S_RELOAD;
              hrst_q   <= 1'b1;
              level_q  <= (level_q == LVL_MAX) ? 4'd0 : level_q + 4'd1;
              timer_q  <= T_INIT;
              sub_q    <= '0;
              banner_q <= B_NONE;
            end
          end
        end
        S_RELOAD: begin
          state_q <= S_PLAY;
          play_q  <= 1'b1;
        end
        S_DEATH: begin
          if (ban_done) begin
            ban_cnt_q <= '0;
            if (lives_q == 3'd0) begin
              state_q  <= S_OVER;
              banner_q <= B_OVER;
            end else begin
              state_q  <= S_PLAY;
              play_q   <= 1'b1;
              hrst_q   <= 1'b1;
              timer_q  <= T_INIT;
              sub_q    <= '0;
              banner_q <= B_NONE;
            end
          end else if (frame_tick_i) begin
            ban_cnt_q <= ban_cnt_q + BAN_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign play_enable_o = play_q;
  assign hero_rst_o    = hrst_q;
  assign bonus_valid_o = bv_q;
  assign bonus_pts_o   = pts_q;
  assign level_o       = level_q;
  assign lives_o       = lives_q;
  assign timer_sec_o   = timer_q;
  assign banner_o      = banner_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever a pulse fires or a phase-level output changes.
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        level_done = 1'b0;
  logic        hero_dead = 1'b0;
  logic        play_enable;
  logic        hero_rst;
  logic        bonus_valid;
  logic [11:0] bonus_pts;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic [9:0]  timer_sec;
  logic [1:0]  banner;

  level_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick_i  (frame_tick),
    .start_i       (start),
    .level_done_i  (level_done),
    .hero_dead_i   (hero_dead),
    .play_enable_o (play_enable),
    .hero_rst_o    (hero_rst),
    .bonus_valid_o (bonus_valid),
    .bonus_pts_o   (bonus_pts),
    .level_o       (level),
    .lives_o       (lives),
    .timer_sec_o   (timer_sec),
    .banner_o      (banner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pe;
    logic        hr;
    logic        bv;
    logic [11:0] pts;
    logic [3:0]  lvl;
    logic [2:0]  lv;
    logic [9:0]  tmr;
    logic [1:0]  ban;
  } snap_t;

  snap_t act_s;
  assign act_s = {play_enable, hero_rst, bonus_valid, bonus_pts, level, lives, timer_sec, banner};

  snap_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic snap_t mk(input bit pe, input bit hr, input bit bv, input int pts,
                               input int lvl, input int lv, input int t, input int ban);
    snap_t s;
    s.pe  = pe;
    s.hr  = hr;
    s.bv  = bv;
    s.pts = 12'(pts);
    s.lvl = 4'(lvl);
    s.lv  = 3'(lv);
    s.tmr = 10'(t);
    s.ban = 2'(ban);
    return s;
  endfunction

  task automatic check(input string name, input logic [33:0] a, input logic [33:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Monitor: phase-level outputs form the change key; pulses always count as events
  initial begin
    logic [9:0] prev;
    logic [9:0] key;
    prev = {1'b0, 4'd0, 3'd3, 2'd0};
    forever begin
      @(negedge clk);
      key = {play_enable, level, lives, banner};
      if (hero_rst || bonus_valid || key != prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got %h expected none", act_s);
        end else begin
          check("event", act_s, exp_q.pop_front());
        end
      end
      prev = key;
    end
  end

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit ld, input bit hd);
    start = s; level_done = ld; hero_dead = hd;
    @(posedge clk);
    #1 start = 1'b0; level_done = 1'b0; hero_dead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full clear sequence from PLAY; returns once the sequencer is back in PLAY
  task automatic do_clear(input int lvl, input int lv, input int t, input bit dead);
    int nl;
    nl = (lvl == 15) ? 0 : lvl + 1;
    exp_q.push_back(mk(0, 0, 0, 0, lvl, lv, t, 1));
    pulse(0, 1, dead);
    ticks(120);
    for (int i = 0; i < t; i++) exp_q.push_back(mk(0, 0, 1, 10, lvl, lv, t - 1 - i, 1));
    exp_q.push_back(mk(0, 1, 0, 0, nl, lv, 300, 0));
    exp_q.push_back(mk(1, 0, 0, 0, nl, lv, 300, 0));
    ticks(t + 1);
    idle(1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", act_s, mk(0, 0, 0, 0, 0, 3, 300, 0));

    // start from IDLE, then a second start in PLAY must be ignored
    exp_q.push_back(mk(1, 1, 0, 0, 0, 3, 300, 0));
    pulse(1, 0, 0);
    idle(1);
    pulse(1, 0, 0);

    // one second of frames, then run the timer out
    ticks(60);
    check("timer_1s", 34'(timer_sec), 34'(299));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2, 0, 2));
    ticks(17940);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 2, 300, 0));
    ticks(120);

    // clear with 5 seconds left
    ticks(17700);
    check("timer_5s", 34'(timer_sec), 34'(5));
    do_clear(0, 2, 5, 1'b0);

    // level_done and hero_dead together: clear wins, lives kept
    do_clear(1, 2, 300, 1'b1);

    // two more deaths to game over
    exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 300, 2));
    pulse(0, 0, 1);
    exp_q.push_back(mk(1, 1, 0, 0, 2, 1, 300, 0));
    ticks(120);
    exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 300, 2));
    pulse(0, 0, 1);
    exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 300, 3));
    ticks(120);
    pulse(0, 1, 1);
    idle(2);
    check("over_hold", act_s, mk(0, 0, 0, 0, 2, 0, 300, 3));
    exp_q.push_back(mk(1, 1, 0, 0, 0, 3, 300, 0));
    pulse(1, 0, 0);

    // sixteen clears: the last wraps level 15 back to 0
    for (int i = 0; i < 16; i++) do_clear(i, 3, 300, 1'b0);
    check("level_wrap", 34'(level), 34'(0));

    // async reset in the middle of BONUS
    exp_q.push_back(mk(0, 0, 0, 0, 0, 3, 300, 1));
    pulse(0, 1, 0);
    ticks(120);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 1, 10, 0, 3, 299 - i, 1));
    ticks(3);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 3, 300, 0));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", act_s, mk(0, 0, 0, 0, 0, 3, 300, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    check("queue_drained", 34'(exp_q.size()), 34'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
